// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg
//   Shared definitions for the elastic pipeline stage register:
//   - EXCCODE_SIZE: exception-code width carried alongside the payload.
//   - psr_state_e:  occupancy encoding, which is also the value of `count`.
//   - psr_ready_f:  whether an occupancy still leaves room for a new beat.
package pipe_skid_reg_pkg;

  localparam int EXCCODE_SIZE = 5;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_ONE   = 2'd1,
    PSR_FULL  = 2'd2
  } psr_state_e;

  // The stage can take a beat whenever at least one slot is free.
  function automatic logic psr_ready_f(input psr_state_e occ);
    return (occ != PSR_FULL);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One storage slot of the stage: payload + exception code + branch-delay flag.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (zeroes all fields)
//     clear_i           zero all fields (has priority over load_i)
//     load_i            capture ld_data_i / ld_exccode_i / ld_bd_i
//     ld_*_i            source fields to load
//     data_o, exccode_o, bd_o  stored fields (all zero when the slot is empty)
module pipe_slot
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXC_W  = EXCCODE_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [EXC_W-1:0]  ld_exccode_i,
  input  logic              ld_bd_i,
  output logic [DATA_W-1:0] data_o,
  output logic [EXC_W-1:0]  exccode_o,
  output logic              bd_o
);

  logic [DATA_W-1:0] data_q;
  logic [EXC_W-1:0]  exccode_q;
  logic              bd_q;

  // Slot storage: clear wins over load so an emptied slot always reads as a nop.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      data_q    <= '0;
      exccode_q <= '0;
      bd_q      <= 1'b0;
    end else if (load_i) begin
      data_q    <= ld_data_i;
      exccode_q <= ld_exccode_i;
      bd_q      <= ld_bd_i;
    end else begin
      data_q    <= data_q;
      exccode_q <= exccode_q;
      bd_q      <= bd_q;
    end
  end

  assign data_o    = data_q;
  assign exccode_o = exccode_q;
  assign bd_o      = bd_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Elastic pipeline stage register with a two-entry skid buffer.
//   MAIN drives the outputs; SKID holds a second beat so that in_ready can be
//   a register (no combinational out_ready -> in_ready path).
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     req                         exception kill: empties both slots (top priority)
//     flush                       discard the input beat presented this cycle
//     in_valid/in_ready           upstream handshake (in_ready registered)
//     in_data/in_exccode/in_bd    incoming beat
//     out_valid/out_ready         downstream handshake
//     out_data/out_exccode/out_bd MAIN slot contents (zero when empty)
//     count                       occupancy 0..2
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXC_W  = EXCCODE_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exccode,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exccode,
  output logic              out_bd,
  output logic [1:0]        count
);

  psr_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;

  logic acc_s, fire_s;
  logic main_load_s, main_clear_s, main_from_skid_s;
  logic skid_load_s, skid_clear_s;

  logic [DATA_W-1:0] skid_data_s, main_src_data_s;
  logic [EXC_W-1:0]  skid_exccode_s, main_src_exccode_s;
  logic              skid_bd_s, main_src_bd_s;

  assign acc_s  = in_valid & in_ready_q & ~flush & ~req;
  assign fire_s = out_valid & out_ready;

  // Occupancy FSM: decides which slot loads/clears and the next occupancy.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_clear_s     = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (req) begin
      // Kill beats everything, including a concurrent fire or accept.
      state_d      = PSR_EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_q)
        PSR_EMPTY: begin
          if (acc_s) begin
            main_load_s = 1'b1;
            state_d     = PSR_ONE;
          end else begin
            state_d = PSR_EMPTY;
          end
        end
        PSR_ONE: begin
          if (fire_s && acc_s) begin
            main_load_s = 1'b1;
            state_d     = PSR_ONE;
          end else if (fire_s) begin
            main_clear_s = 1'b1;
            state_d      = PSR_EMPTY;
          end else if (acc_s) begin
            // Downstream stalled but in_ready was already high: park in SKID.
            skid_load_s = 1'b1;
            state_d     = PSR_FULL;
          end else begin
            state_d = PSR_ONE;
          end
        end
        PSR_FULL: begin
          if (fire_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
            state_d          = PSR_ONE;
          end else begin
            state_d = PSR_FULL;
          end
        end
        default: begin
          state_d      = PSR_EMPTY;
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // in_ready is computed from the next occupancy so it can be registered.
  always_comb begin
    in_ready_d = psr_ready_f(state_d);
  end

  // MAIN source mux: the incoming beat, or the older beat waiting in SKID.
  always_comb begin
    if (main_from_skid_s) begin
      main_src_data_s    = skid_data_s;
      main_src_exccode_s = skid_exccode_s;
      main_src_bd_s      = skid_bd_s;
    end else begin
      main_src_data_s    = in_data;
      main_src_exccode_s = in_exccode;
      main_src_bd_s      = in_bd;
    end
  end

  // Occupancy and in_ready registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PSR_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (main_clear_s),
    .load_i       (main_load_s),
    .ld_data_i    (main_src_data_s),
    .ld_exccode_i (main_src_exccode_s),
    .ld_bd_i      (main_src_bd_s),
    .data_o       (out_data),
    .exccode_o    (out_exccode),
    .bd_o         (out_bd)
  );

  pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (skid_clear_s),
    .load_i       (skid_load_s),
    .ld_data_i    (in_data),
    .ld_exccode_i (in_exccode),
    .ld_bd_i      (in_bd),
    .data_o       (skid_data_s),
    .exccode_o    (skid_exccode_s),
    .bd_o         (skid_bd_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != PSR_EMPTY);
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Self-checking bench for pipe_skid_reg. The reference model is a plain
//   FIFO queue of beats (depth 2) plus a ready flag, updated once per edge.
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        req;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_exccode;
  logic        in_bd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_exccode;
  logic        out_bd;
  logic [1:0]  count;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  e;
    logic        b;
  } beat_t;

  beat_t q[$];
  logic  m_ready = 1'b1;

  pipe_skid_reg #(.DATA_W(32), .EXC_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_exccode  (in_exccode),
    .in_bd       (in_bd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_exccode (out_exccode),
    .out_bd      (out_bd),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: evaluate handshake on the pre-edge state, update the FIFO model.
  task automatic cycle();
    logic m_acc, m_fire;
    m_acc  = in_valid && m_ready && !flush && !req;
    m_fire = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (reset || req) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      if (m_fire) void'(q.pop_front());
      if (m_acc) q.push_back(beat_t'{in_data, in_exccode, in_bd});
      m_ready = (q.size() < 2);
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; in_exccode = 5'd0; in_bd = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    cycle(); cycle();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passes++;
    checks++; if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    checks++; if (out_exccode !== 5'd0 || out_bd !== 1'b0) $display("FAIL reset_side got %0d/%b want 0/0", out_exccode, out_bd); else passes++;
  endtask

  task automatic test_streaming();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = i;
      cycle();
      checks++; if (out_data !== 32'(i)) $display("FAIL stream_data[%0d] got %h want %h", i, out_data, i); else passes++;
      checks++; if (count !== 2'd1) $display("FAIL stream_count[%0d] got %0d want 1", i, count); else passes++;
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (count !== 2'd0) $display("FAIL stream_drain got %0d want 0", count); else passes++;
  endtask

  task automatic test_skid();
    logic [31:0] seen[$];
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; cycle();
    in_data = 32'hB; cycle();
    checks++; if (count !== 2'd2) $display("FAIL skid_count got %0d want 2", count); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL skid_in_ready got %b want 0", in_ready); else passes++;
    in_data = 32'hC; cycle();
    checks++; if (count !== 2'd2 || out_data !== 32'hA) $display("FAIL skid_hold got %0d/%h want 2/a", count, out_data); else passes++;
    seen.push_back(out_data);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (in_valid && in_ready) begin
        cycle();
        in_valid = 1'b0;
      end else begin
        cycle();
      end
      if (out_valid) seen.push_back(out_data);
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC)
      $display("FAIL skid_order got %0d beats first %h want a,b,c", seen.size(), seen[0]);
    else passes++;
    checks++; if (count !== 2'd0) $display("FAIL skid_drain got %0d want 0", count); else passes++;
  endtask

  task automatic test_flush();
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; cycle();
    in_data = 32'h6; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 2'd1 || out_data !== 32'h5) $display("FAIL flush_keep got %0d/%h want 1/5", count, out_data); else passes++;
    out_ready = 1'b1; cycle();
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_empty got %0d/%b want 0/0", count, out_valid); else passes++;
  endtask

  task automatic test_req();
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_exccode = 5'd4; in_bd = 1'b1;
    in_data = 32'h7; cycle();
    in_data = 32'h8; cycle();
    checks++; if (count !== 2'd2) $display("FAIL req_full got %0d want 2", count); else passes++;
    in_valid = 1'b0; req = 1'b1; out_ready = 1'b1; cycle();
    req = 1'b0;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_exccode !== 5'd0 || out_bd !== 1'b0)
      $display("FAIL req_kill got cnt %0d v %b d %h e %0d b %b want all 0", count, out_valid, out_data, out_exccode, out_bd);
    else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL req_in_ready got %b want 1", in_ready); else passes++;
  endtask

  task automatic test_sideband();
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; cycle();
    in_data = 32'h22; in_exccode = 5'd12; in_bd = 1'b1; cycle();
    in_data = 32'h33; in_exccode = 5'd0; in_bd = 1'b0; cycle();
    out_ready = 1'b1; cycle();
    checks++;
    if (out_data !== 32'h22 || out_exccode !== 5'd12 || out_bd !== 1'b1)
      $display("FAIL side_skid got %h/%0d/%b want 22/12/1", out_data, out_exccode, out_bd);
    else passes++;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'h33 || out_exccode !== 5'd0 || out_bd !== 1'b0)
      $display("FAIL side_next got %h/%0d/%b want 33/0/0", out_data, out_exccode, out_bd);
    else passes++;
    cycle();
  endtask

  task automatic test_random();
    beat_t exp_b;
    int    bad = 0;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      req        = ($urandom_range(0, 31) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_data    = $urandom;
      in_exccode = 5'($urandom_range(0, 31));
      in_bd      = 1'($urandom_range(0, 1));
      cycle();
      exp_b = (q.size() != 0) ? q[0] : beat_t'(0);
      checks++;
      if (out_valid !== (q.size() != 0) || count !== 2'(q.size()) || in_ready !== m_ready ||
          out_data !== exp_b.d || out_exccode !== exp_b.e || out_bd !== exp_b.b) begin
        bad++;
        if (bad <= 10)
          $display("FAIL rand[%0d] got v%b c%0d r%b d%h e%0d b%b want v%b c%0d r%b d%h e%0d b%b",
                   n, out_valid, count, in_ready, out_data, out_exccode, out_bd,
                   q.size() != 0, q.size(), m_ready, exp_b.d, exp_b.e, exp_b.b);
      end else passes++;
      checks++;
      if (out_valid !== (count != 2'd0)) $display("FAIL rand_inv[%0d] v%b c%0d", n, out_valid, count); else passes++;
    end
    idle_inputs(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_req();
    test_sideband();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline stage register, the next generation of the fixed stage registers between pipeline stages (F/D, D/E, E/M, M/W). It replaces the global `stall` with a local valid/ready handshake and adds a two-entry skid buffer, so the stage can hold a stalled instruction without a combinational ready path. It keeps the existing exception-kill (`req`) and bubble-insert (`flush`) semantics. The payload is a packed vector, plus the exception code and branch-delay flag carried alongside it.

## Interface
- `DATA_W`, 32: width of the packed payload (instr, PC, operands, results, write-back info, packed by the caller).
- `EXC_W`, `EXCCODE_SIZE`: width of the exception code.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: exception/interrupt kill. Highest priority; empties the stage.
- `flush` in 1: the input beat presented this cycle is consumed and discarded, producing a bubble.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage can accept. Registered.
- `in_data` in DATA_W: incoming payload.
- `in_exccode` in EXC_W: incoming exception code.
- `in_bd` in 1: incoming branch-delay flag.
- `out_valid` out 1: the main slot holds a beat.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: main-slot payload.
- `out_exccode` out EXC_W: main-slot exception code.
- `out_bd` out 1: main-slot branch-delay flag.
- `count` out 2: occupancy, 0..2.

## Operation
- Two slots:
  - MAIN drives all `out_*` outputs.
  - SKID is a holding slot that is never visible at the outputs.
- The fields of an empty slot are all zero, so downstream sees instr 0 (nop) with ExcCode 0 and BD 0.
- Events:
  - `acc = in_valid & in_ready & ~flush & ~req` (beat is stored).
  - `drop = in_valid & in_ready & (flush | req)` (beat is consumed and discarded).
  - `fire = out_valid & out_ready`.
- States are EMPTY (`count`=0), ONE (1) and FULL (2).
- EMPTY:
  - `acc`: MAIN←in, go to ONE.
  - Otherwise: stay in EMPTY.
- ONE:
  - `fire` and `acc`: MAIN←in, stay in ONE.
  - `fire` only: clear MAIN, go to EMPTY.
  - `acc` only: SKID←in, go to FULL.
  - Neither: hold.
- FULL:
  - `in_ready`=0.
  - `fire`: MAIN←SKID, clear SKID, go to ONE.
  - Otherwise: hold.
- `req` overrides every row above. Both slots are cleared and the stage goes to EMPTY, even if `fire` or `acc` would occur the same cycle. A concurrent `fire` still counts as taken by downstream, because `req` flushes downstream too.
- `flush` affects only the input side. MAIN and SKID contents are unaffected, and `fire` proceeds normally.
- `flush` with `in_valid`=0 has no effect.
- Beat ordering is strict FIFO. No beat is duplicated or lost except by `drop` or `req`.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - `out_valid`=0, `out_data`=0, `out_exccode`=0, `out_bd`=0.
  - `count`=0, `in_ready`=1.
- `reset` beats `req` beats handshake.
- Latency: a beat accepted at edge N appears on `out_*` after edge N, when the stage was EMPTY (or ONE with a concurrent `fire`).
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` is registered as `next_count < 2`.
  - There is no combinational path `out_ready`→`in_ready` and none `in_valid`→`out_valid`.
  - Because of this, a ONE state with `out_ready`=0 still accepts, and the beat lands in SKID.
- `count` and `out_valid` are updated on the same edge. `out_valid == (count != 0)` always holds.
- `reset` or `req` asserted mid-transfer: the beat being presented that cycle is lost. `in_ready` is 1 on the next cycle.

## Structure
- Shared package / `macros.v`:
  - `EXCCODE_SIZE`.
  - Occupancy encodings `PSR_EMPTY`=2'd0, `PSR_ONE`=2'd1, `PSR_FULL`=2'd2.
- One sub-module, `pipe_slot`:
  - Holds payload + exccode + bd.
  - Controls are `load` (from a selected source) and `clear` (zero all fields). Clear has priority.
  - Instantiated twice, as MAIN and SKID.
- The top level holds the occupancy FSM, the `in_ready` register and the MAIN source mux (`in` vs SKID).

## Test plan
- **Reset:** drive `reset` for 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF -> after release, `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1.
- **Streaming:** `out_ready`=1, feed 0x1,0x2,0x3 on consecutive cycles -> `out_data` is 0x1,0x2,0x3 one cycle later each, and `count` stays 1.
- **Backpressure/skid:**
  - With `out_ready`=0, feed 0xA then 0xB -> `count`=2 and `in_ready`=0; 0xC is held upstream.
  - Raise `out_ready` -> output is 0xA, then 0xB, then 0xC, with no loss or duplication.
- **Flush:** in ONE holding 0x5 with `out_ready`=0, present 0x6 with `flush`=1 -> `count` stays 1 and `out_data`=0x5. Next `fire` -> EMPTY.
- **Exception kill:** in FULL (0x7, 0x8, `in_exccode`=4, `in_bd`=1), assert `req` with `out_ready`=1 -> next cycle `count`=0, all outputs 0, `in_ready`=1.
- **Sideband integrity:** feed a beat with `in_exccode`=12 and `in_bd`=1 through the SKID path -> it emerges intact with its payload; the following beat shows exccode 0 and bd 0.
